gray_window_3x3: RTL and testbench

Streaming front end for the edge-detection path. It converts each incoming RGB camera pixel to 8-bit luma and holds the two previous lines in on-chip line buffers. From these it assembles the 3×3 neighbourhood around every interior pixel, and emits one window per cycle for the Sobel/gradient stage. It sits between the D8M RGB output register stage and `edge_detect`.

---
 rtl/gray_window_3x3.sv | 168 ++++++++++++++++
 tb/tb_gray_window_3x3.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_window_3x3.sv
// RGB-to-luma front end that assembles a 3x3 luma neighbourhood around every
// interior pixel, using two line buffers and a column shift register.
module gray_window_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  output logic        out_valid,
  output logic [71:0] out_win,
  output logic [8:0]  out_row,
  output logic [9:0]  out_col,
  output logic        frame_done
);

  localparam int CW = 10;
  localparam int RW = 9;
  localparam int AW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Reset asserts asynchronously, releases two clocks after RESET_N rises.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [7:0] y_in;
  assign y_in = 8'((16'd77 * {8'd0, in_R} + 16'd150 * {8'd0, in_G}
                    + 16'd29 * {8'd0, in_B}) >> 8);

  logic [CW-1:0] col_reg, col_next, pos_col;
  logic [RW-1:0] row_reg, row_next, pos_row;

  always_comb begin
    pos_col  = in_sof ? '0 : col_reg;
    pos_row  = in_sof ? '0 : row_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (in_valid) begin
      if (pos_col == COL_LAST) begin
        col_next = '0;
        row_next = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
      end else begin
        col_next = pos_col + CW'(1);
        row_next = pos_row;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Stage 1: luma, position and flags; line-buffer read issued in parallel.
  logic          s1_valid_reg;
  logic [7:0]    y_s1_reg;
  logic [CW-1:0] col_s1_reg;
  logic [RW-1:0] row_s1_reg;
  logic          emit_s1_reg;
  logic          last_s1_reg;
  logic          fwd_hit_reg;
  logic [1:0][7:0] fwd_data_reg;
  logic [1:0][7:0] lb_old;
  logic [1:0][7:0] lb_wr_data;

  // LB1 takes the new luma, LB0 takes what LB1 held at that column.
  assign lb_wr_data[1] = y_s1_reg;
  assign lb_wr_data[0] = lb_old[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      y_s1_reg     <= '0;
      col_s1_reg   <= '0;
      row_s1_reg   <= '0;
      emit_s1_reg  <= 1'b0;
      last_s1_reg  <= 1'b0;
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        y_s1_reg     <= y_in;
        col_s1_reg   <= pos_col;
        row_s1_reg   <= pos_row;
        emit_s1_reg  <= (pos_row >= RW'(2)) && (pos_col >= CW'(2));
        last_s1_reg  <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        // A read colliding with the write of the same slot must see that write.
        fwd_hit_reg  <= s1_valid_reg && (col_s1_reg == pos_col);
        fwd_data_reg <= lb_wr_data;
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      logic [7:0] mem [IMG_W];
      logic [7:0] rd_q;

      always_ff @(posedge CLOCK_50) begin
        if (s1_valid_reg) mem[col_s1_reg[AW-1:0]] <= lb_wr_data[gi];
        if (in_valid)     rd_q <= mem[pos_col[AW-1:0]];
      end

      assign lb_old[gi] = fwd_hit_reg ? fwd_data_reg[gi] : rd_q;
    end
  endgenerate

  // The two most recent columns are kept; the incoming column completes the
  // 3x3 window. Index [col][row], row 0 = top (oldest line).
  logic [1:0][2:0][7:0] hist_reg;
  logic [2:0][2:0][7:0] win_next;
  logic [71:0]          win_flat;

  assign win_next[0] = hist_reg[0];
  assign win_next[1] = hist_reg[1];
  assign win_next[2] = {y_s1_reg, lb_old[1], lb_old[0]};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      for (gj = 0; gj < 3; gj++) begin : g_col
        assign win_flat[(gi*3 + gj)*8 +: 8] = win_next[gj][gi];
      end
    end
  endgenerate

  // Stage 2: shift the column history and register the outputs.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_win    <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (s1_valid_reg) begin
      hist_reg   <= {win_next[2], win_next[1]};
      out_valid  <= emit_s1_reg;
      frame_done <= last_s1_reg;
      if (emit_s1_reg) begin
        out_win <= win_flat;
        out_row <= row_s1_reg - RW'(1);
        out_col <= col_s1_reg - CW'(1);
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_window_3x3.sv
// Scoreboard bench for gray_window_3x3 on an 8x6 image: a frame-buffer model
// predicts each window and its due cycle; a negedge monitor compares.
module tb_gray_window_3x3;

  localparam int W = 8;
  localparam int H = 6;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof   = 1'b0;
  logic [7:0]  in_R = '0, in_G = '0, in_B = '0;
  logic        out_valid;
  logic [71:0] out_win;
  logic [8:0]  out_row;
  logic [9:0]  out_col;
  logic        frame_done;

  gray_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_R       (in_R),
    .in_G       (in_G),
    .in_B       (in_B),
    .out_valid  (out_valid),
    .out_win    (out_win),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    bit          last;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  bit first_seen = 1'b0;
  logic [71:0] first_win;
  logic [18:0] first_rc;

  // Reference model: luma image of the current frame plus the raster position.
  byte unsigned fb [H][W];
  int m_row = 0;
  int m_col = 0;

  function automatic int luma(int r, int g, int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (cyc >= 3) begin
      if (out_valid === 1'b1) begin
        win_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_win  = out_win;
          first_rc   = {out_row, out_col};
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        check(out_valid === 1'b1, "out_valid", 72'(out_valid), 72'd1);
        check(out_win === mon_e.win, "out_win", out_win, mon_e.win);
        check(out_row === 9'(mon_e.row), "out_row", 72'(out_row), 72'(mon_e.row));
        check(out_col === 10'(mon_e.col), "out_col", 72'(out_col), 72'(mon_e.col));
        check(frame_done === mon_e.last, "frame_done", 72'(frame_done), 72'(mon_e.last));
        $display("win row=%0d col=%0d data=%h frame_done=%0d",
                 out_row, out_col, out_win, frame_done);
      end else begin
        check(out_valid === 1'b0 && frame_done === 1'b0, "idle_slot",
              72'({out_valid, frame_done}), 72'd0);
      end
    end
  end

  // One clock slot, entered and left at posedge+1.
  task automatic slot(input bit v, input bit sof, input byte unsigned r,
                      input byte unsigned g, input byte unsigned b);
    int pr, pc;
    logic [71:0] w;
    exp_t e;
    in_valid = v;
    in_sof   = sof;
    in_R = r; in_G = g; in_B = b;
    if (v) begin
      pr = sof ? 0 : m_row;
      pc = sof ? 0 : m_col;
      fb[pr][pc] = 8'(luma(r, g, b));
      if (pr >= 2 && pc >= 2) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[(i*3 + j)*8 +: 8] = fb[pr-2+i][pc-2+j];
        e.win  = w;
        e.row  = pr - 1;
        e.col  = pc - 1;
        e.last = (pr == H-1) && (pc == W-1);
        e.due  = cyc + 2;
        sb_q.push_back(e);
      end
      pc++;
      if (pc == W) begin
        pc = 0;
        pr++;
        if (pr == H) pr = 0;
      end
      m_row = pr;
      m_col = pc;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // mode 0: grey ramp 8*row+col; 1: random colour; 2: luma corner cases.
  task automatic colour(input int mode, input int k, output byte unsigned r,
                        output byte unsigned g, output byte unsigned b);
    int pr, pc;
    pr = (k / W) % H;
    pc = k % W;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    if (mode == 0) begin
      r = 8'(8 * pr + pc); g = r; b = r;
    end else if (mode == 2) begin
      if (pr == 1 && pc == 1) begin r = 255; g = 255; b = 255; end
      if (pr == 1 && pc == 2) begin r = 255; g = 0;   b = 0;   end
      if (pr == 2 && pc == 3) begin r = 0;   g = 255; b = 0;   end
      if (pr == 3 && pc == 4) begin r = 0;   g = 0;   b = 255; end
      if (pr == 4 && pc == 6) begin r = 0;   g = 0;   b = 0;   end
    end
  endtask

  task automatic run_pixels(input int n, input int mode, input int gap_pct,
                            input bit sof_first);
    byte unsigned r, g, b;
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(1);
      colour(mode, k, r, g, b);
      slot(1'b1, sof_first && k == 0, r, g, b);
    end
  endtask

  task automatic check_counts(input string name, input int w0, input int f0,
                              input int w_req, input int f_req);
    check(win_cnt - w0 == w_req, {name, "_windows"}, 72'(win_cnt - w0), 72'(w_req));
    check(fd_cnt - f0 == f_req, {name, "_frame_done"}, 72'(fd_cnt - f0), 72'(f_req));
  endtask

  task automatic check_zero_outputs(input string name);
    check(out_valid === 1'b0, {name, "_out_valid"}, 72'(out_valid), 72'd0);
    check(frame_done === 1'b0, {name, "_frame_done"}, 72'(frame_done), 72'd0);
    check(out_win === 72'd0, {name, "_out_win"}, out_win, 72'd0);
    check(out_row === 9'd0, {name, "_out_row"}, 72'(out_row), 72'd0);
    check(out_col === 10'd0, {name, "_out_col"}, 72'(out_col), 72'd0);
  endtask

  int w0, f0;

  initial begin
    RESET_N = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_zero_outputs("reset_state");
    RESET_N = 1'b1;
    idle(4);

    // Ramp frame, continuous, sof on the first pixel.
    w0 = win_cnt; f0 = fd_cnt; first_seen = 1'b0;
    run_pixels(W * H, 0, 0, 1'b1);
    idle(4);
    check_counts("ramp", w0, f0, 24, 1);
    check(first_win === 72'h12_11_10_0a_09_08_02_01_00, "ramp_first_win",
          first_win, 72'h12_11_10_0a_09_08_02_01_00);
    check(first_rc === {9'd1, 10'd1}, "ramp_first_centre", 72'(first_rc),
          72'({9'd1, 10'd1}));

    // Luma corner cases placed at interior centres.
    w0 = win_cnt; f0 = fd_cnt;
    run_pixels(W * H, 2, 0, 1'b1);
    idle(4);
    check_counts("luma", w0, f0, 24, 1);

    // Same ramp with roughly half the input cycles idle.
    w0 = win_cnt; f0 = fd_cnt;
    run_pixels(W * H, 0, 50, 1'b1);
    idle(4);
    check_counts("gapped", w0, f0, 24, 1);

    // Mid-line sof at (3,4): 8 windows before it, then a full new frame.
    w0 = win_cnt; f0 = fd_cnt;
    run_pixels(3 * W + 4, 1, 0, 1'b1);
    run_pixels(W * H, 1, 0, 1'b1);
    idle(4);
    check_counts("midline_sof", w0, f0, 32, 1);

    // Asynchronous reset just after pixel (3,3) is accepted.
    run_pixels(3 * W + 4, 0, 0, 1'b1);
    #2;
    RESET_N  = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    sb_q.delete();
    #1;
    check_zero_outputs("async_reset");
    repeat (3) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    m_row = 0;
    m_col = 0;
    idle(4);
    w0 = win_cnt; f0 = fd_cnt;
    run_pixels(W * H, 0, 0, 1'b0);
    idle(4);
    check_counts("after_reset", w0, f0, 24, 1);

    // Two gapped random frames; the second relies on counter wrap, no sof.
    w0 = win_cnt; f0 = fd_cnt;
    run_pixels(2 * W * H, 1, 30, 1'b1);
    idle(6);
    check_counts("wrap", w0, f0, 48, 2);

    check(sb_q.size() == 0, "queue_drained", 72'(sb_q.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
